// File: rtl/ram_bus_pkg.sv
// Shared widths, instruction-type codes, IO addresses and FSM states for the
// memory-side responder, plus access-size and load-extension helpers.
package ram_bus_pkg;

  localparam int ADDRESS_WIDTH     = 32;
  localparam int INSTRUCTION_WIDTH = 32;
  localparam int INST_TYPE_WIDTH   = 4;

  localparam logic [INST_TYPE_WIDTH-1:0] LB  = 4'd0;
  localparam logic [INST_TYPE_WIDTH-1:0] LH  = 4'd1;
  localparam logic [INST_TYPE_WIDTH-1:0] LW  = 4'd2;
  localparam logic [INST_TYPE_WIDTH-1:0] LBU = 4'd3;
  localparam logic [INST_TYPE_WIDTH-1:0] LHU = 4'd4;
  localparam logic [INST_TYPE_WIDTH-1:0] SB  = 4'd5;
  localparam logic [INST_TYPE_WIDTH-1:0] SH  = 4'd6;
  localparam logic [INST_TYPE_WIDTH-1:0] SW  = 4'd7;

  localparam logic [ADDRESS_WIDTH-1:0] IO_ADDR_0 = 32'h0003_0000;
  localparam logic [ADDRESS_WIDTH-1:0] IO_ADDR_1 = 32'h0003_0004;

  typedef enum logic [2:0] {
    IDLE,
    ST_LATCH,
    STORE,
    LOAD,
    FETCH
  } bus_state_e;

  function automatic logic [2:0] access_size(input logic [INST_TYPE_WIDTH-1:0] t);
    case (t)
      LB, LBU, SB: access_size = 3'd1;
      LH, LHU, SH: access_size = 3'd2;
      default:     access_size = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [INST_TYPE_WIDTH-1:0] t,
                                              input logic [31:0] d);
    case (t)
      LB:      load_extend = {{24{d[7]}}, d[7:0]};
      LH:      load_extend = {{16{d[15]}}, d[15:0]};
      LBU:     load_extend = {24'd0, d[7:0]};
      LHU:     load_extend = {16'd0, d[15:0]};
      default: load_extend = d;
    endcase
  endfunction

endpackage

// File: rtl/ram_bus_if.sv
// Bundle of the ROB store port, load-buffer port, fetch port and 8-bit RAM port.
// The responder uses the slave view; the core/RAM side uses the master view.
interface ram_bus_if;
  import ram_bus_pkg::*;

  logic                         rdy_in;
  logic                         flush_in;

  logic                         rob_en_in;
  logic [ADDRESS_WIDTH-1:0]     rob_addr_in;
  logic [31:0]                  rob_wdata_in;
  logic [INST_TYPE_WIDTH-1:0]   rob_inst_type_in;
  logic                         rob_rdy_out;
  logic                         rob_finish_out;

  logic                         lb_en_in;
  logic [ADDRESS_WIDTH-1:0]     lb_addr_in;
  logic [INST_TYPE_WIDTH-1:0]   lb_inst_type_in;
  logic                         lb_finish_out;
  logic [31:0]                  lb_data_out;

  logic                         if_en_in;
  logic [ADDRESS_WIDTH-1:0]     if_pc_in;
  logic                         if_finish_out;
  logic [INSTRUCTION_WIDTH-1:0] if_inst_out;

  logic [7:0]                   mem_din;
  logic [7:0]                   mem_dout;
  logic [ADDRESS_WIDTH-1:0]     mem_a;
  logic                         mem_wr;
  logic                         io_buffer_full;

  modport slave (
    input  rdy_in, flush_in,
    input  rob_en_in, rob_addr_in, rob_wdata_in, rob_inst_type_in,
    output rob_rdy_out, rob_finish_out,
    input  lb_en_in, lb_addr_in, lb_inst_type_in,
    output lb_finish_out, lb_data_out,
    input  if_en_in, if_pc_in,
    output if_finish_out, if_inst_out,
    input  mem_din, io_buffer_full,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output rdy_in, flush_in,
    output rob_en_in, rob_addr_in, rob_wdata_in, rob_inst_type_in,
    input  rob_rdy_out, rob_finish_out,
    output lb_en_in, lb_addr_in, lb_inst_type_in,
    input  lb_finish_out, lb_data_out,
    output if_en_in, if_pc_in,
    input  if_finish_out, if_inst_out,
    output mem_din, io_buffer_full,
    input  mem_dout, mem_a, mem_wr
  );

endinterface

// File: rtl/ram_bus.sv
// Serialises committed stores, loads and instruction fetches into little-endian
// byte accesses on the 8-bit RAM port and returns completion pulses and data.
module ram_bus
  import ram_bus_pkg::*;
(
  input  logic      clk_in,
  input  logic      rst_in,
  ram_bus_if.slave  bus
);

  bus_state_e                 state_reg;
  logic [2:0]                 cnt_reg;
  logic [2:0]                 size_reg;
  logic [ADDRESS_WIDTH-1:0]   addr_reg;
  logic [31:0]                wdata_reg;
  logic [31:0]                data_reg;
  logic [INST_TYPE_WIDTH-1:0] type_reg;
  logic                       rob_rdy_reg;
  logic                       rob_finish_reg;
  logic                       lb_finish_reg;
  logic                       if_finish_reg;
  logic [31:0]                lb_data_reg;
  logic [31:0]                if_inst_reg;

  logic                       io_stall;
  logic                       last_byte;
  logic [1:0]                 lane;
  logic [31:0]                assembled;

  assign io_stall  = ((addr_reg == IO_ADDR_0) || (addr_reg == IO_ADDR_1)) && bus.io_buffer_full;
  assign last_byte = (cnt_reg == size_reg - 3'd1);

  assign bus.mem_a    = addr_reg + {29'd0, cnt_reg};
  assign bus.mem_wr   = bus.rdy_in && (state_reg == STORE) && !io_stall;
  assign bus.mem_dout = wdata_reg[{cnt_reg[1:0], 3'b000} +: 8];

  // RAM data lags its address by one cycle, so the byte arriving now belongs
  // to lane cnt-1; a count of 4 wraps to lane 3 in two bits.
  always_comb begin
    lane      = cnt_reg[1:0] - 2'd1;
    assembled = data_reg;
    assembled[{lane, 3'b000} +: 8] = bus.mem_din;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg      <= IDLE;
      cnt_reg        <= 3'd0;
      size_reg       <= 3'd0;
      addr_reg       <= '0;
      wdata_reg      <= 32'd0;
      data_reg       <= 32'd0;
      type_reg       <= '0;
      rob_rdy_reg    <= 1'b0;
      rob_finish_reg <= 1'b0;
      lb_finish_reg  <= 1'b0;
      if_finish_reg  <= 1'b0;
      lb_data_reg    <= 32'd0;
      if_inst_reg    <= 32'd0;
    end else if (bus.rdy_in) begin
      rob_finish_reg <= 1'b0;
      lb_finish_reg  <= 1'b0;
      if_finish_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          cnt_reg     <= 3'd0;
          rob_rdy_reg <= 1'b1;
          if (!bus.flush_in) begin
            if (bus.rob_en_in) begin
              state_reg   <= ST_LATCH;
              rob_rdy_reg <= 1'b0;
            end else if (bus.lb_en_in) begin
              state_reg   <= LOAD;
              addr_reg    <= bus.lb_addr_in;
              type_reg    <= bus.lb_inst_type_in;
              size_reg    <= access_size(bus.lb_inst_type_in);
              rob_rdy_reg <= 1'b0;
            end else if (bus.if_en_in) begin
              state_reg   <= FETCH;
              addr_reg    <= bus.if_pc_in;
              size_reg    <= 3'd4;
              rob_rdy_reg <= 1'b0;
            end
          end
        end
        // Store operands only become valid one cycle after the request rises.
        ST_LATCH: begin
          addr_reg  <= bus.rob_addr_in;
          wdata_reg <= bus.rob_wdata_in;
          type_reg  <= bus.rob_inst_type_in;
          size_reg  <= access_size(bus.rob_inst_type_in);
          cnt_reg   <= 3'd0;
          state_reg <= STORE;
        end
        STORE: begin
          if (!io_stall) begin
            if (last_byte) begin
              state_reg      <= IDLE;
              cnt_reg        <= 3'd0;
              rob_finish_reg <= 1'b1;
              rob_rdy_reg    <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + 3'd1;
            end
          end
        end
        LOAD, FETCH: begin
          if (bus.flush_in) begin
            state_reg   <= IDLE;
            cnt_reg     <= 3'd0;
            rob_rdy_reg <= 1'b1;
          end else begin
            if (cnt_reg != 3'd0) begin
              data_reg <= assembled;
            end
            if (cnt_reg == size_reg) begin
              state_reg   <= IDLE;
              cnt_reg     <= 3'd0;
              rob_rdy_reg <= 1'b1;
              if (state_reg == LOAD) begin
                lb_finish_reg <= 1'b1;
                lb_data_reg   <= load_extend(type_reg, assembled);
              end else begin
                if_finish_reg <= 1'b1;
                if_inst_reg   <= assembled;
              end
            end else begin
              cnt_reg <= cnt_reg + 3'd1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.rob_rdy_out    = rob_rdy_reg;
  assign bus.rob_finish_out = rob_finish_reg;
  assign bus.lb_finish_out  = lb_finish_reg;
  assign bus.lb_data_out    = lb_data_reg;
  assign bus.if_finish_out  = if_finish_reg;
  assign bus.if_inst_out    = if_inst_reg;

endmodule

// File: tb/tb_ram_bus.sv
// Scoreboard bench for ram_bus: drivers push expected writes, finish cycles and
// data computed from a byte-array memory model; monitors pop and compare.
module tb_ram_bus;
  import ram_bus_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    logic [31:0] data;
    int          fin;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  ram_bus_if bus ();

  ram_bus dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] ram     [0:1023];
  logic [7:0] ref_mem [0:1023];

  wr_t  wr_q[$];
  int   st_q[$];
  exp_t lb_q[$];
  exp_t if_q[$];
  logic [31:0] last_if = 32'd0;

  // RAM: writes commit at the edge, read data appears one cycle after the address
  always @(posedge clk) begin
    if (bus.mem_wr && bus.mem_a < 32'd1024) ram[bus.mem_a[9:0]] <= bus.mem_dout;
    bus.mem_din <= ram[bus.mem_a[9:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    tests++;
    fails++;
    $display("FAIL %s: actual=1 required=0 (unexpected at cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin : wr_mon
    wr_t w;
    if (!rst && bus.mem_wr) begin
      if (wr_q.size() == 0) begin
        unexpected("mem_wr");
      end else begin
        w = wr_q.pop_front();
        check("wr_addr", bus.mem_a, w.addr);
        check("wr_data", {24'd0, bus.mem_dout}, {24'd0, w.data});
        $display("[TB] write  a=%08h d=%02h cycle %0d", bus.mem_a, bus.mem_dout, cyc);
      end
    end
  end

  always begin : pulse_mon
    exp_t e;
    int   f;
    @(posedge clk);
    #1;
    if (!rst) begin
      if (bus.rob_finish_out) begin
        if (st_q.size() == 0) unexpected("rob_finish");
        else begin
          f = st_q.pop_front();
          check("rob_finish_cycle", cyc, f);
          $display("[TB] store  done cycle %0d", cyc);
        end
      end
      if (bus.lb_finish_out) begin
        if (lb_q.size() == 0) unexpected("lb_finish");
        else begin
          e = lb_q.pop_front();
          check("lb_data", bus.lb_data_out, e.data);
          check("lb_finish_cycle", cyc, e.fin);
          $display("[TB] load   d=%08h cycle %0d", bus.lb_data_out, cyc);
        end
      end
      if (bus.if_finish_out) begin
        if (if_q.size() == 0) unexpected("if_finish");
        else begin
          e = if_q.pop_front();
          last_if = e.data;
          check("if_inst", bus.if_inst_out, e.data);
          check("if_finish_cycle", cyc, e.fin);
          $display("[TB] fetch  d=%08h cycle %0d", bus.if_inst_out, cyc);
        end
      end
    end
  end

  function automatic int tsize(input logic [3:0] t);
    if (t == LB || t == LBU || t == SB) return 1;
    if (t == LH || t == LHU || t == SH) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_value(input logic [31:0] addr, input int n, input bit sgn);
    longint v = 0;
    for (int i = 0; i < n; i++)
      v += longint'(ref_mem[(addr + i) % 1024]) << (8 * i);
    if (sgn && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic push_store(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] t, input int stalls, input int c0);
    logic [7:0] b;
    for (int i = 0; i < tsize(t); i++) begin
      b = 8'((data >> (8 * i)) & 32'hFF);
      wr_q.push_back('{addr + i, b});
      if (addr + i < 1024) ref_mem[addr + i] = b;
    end
    st_q.push_back(c0 + tsize(t) + 2 + stalls);
  endtask

  task automatic push_load(input logic [31:0] addr, input logic [3:0] t, input int c0);
    lb_q.push_back('{ref_value(addr, tsize(t), (t == LB || t == LH)), c0 + tsize(t) + 2});
  endtask

  task automatic push_fetch(input logic [31:0] pc, input int c0);
    if_q.push_back('{ref_value(pc, 4, 1'b0), c0 + 6});
  endtask

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic bit fin_of(input int which);
    if (which == 0) return bus.rob_finish_out;
    if (which == 1) return bus.lb_finish_out;
    return bus.if_finish_out;
  endfunction

  task automatic wait_fin(input int which, input string name);
    for (int k = 0; k < 60; k++) begin
      wait_cycle();
      if (fin_of(which)) return;
    end
    tests++;
    fails++;
    $display("FAIL %s_timeout: actual=no finish required=finish within 60 cycles", name);
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] t, input int flush_at);
    int c0 = cyc;
    bus.rob_en_in = 1'b1;
    bus.rob_addr_in = addr;
    bus.rob_wdata_in = data;
    bus.rob_inst_type_in = t;
    push_store(addr, data, t, 0, c0);
    wait_cycle();
    check("rob_rdy_busy", {31'd0, bus.rob_rdy_out}, 32'd0);
    if (flush_at > 0) begin
      while (cyc < c0 + flush_at) wait_cycle();
      bus.flush_in = 1'b1;
      wait_cycle();
      bus.flush_in = 1'b0;
      if (!bus.rob_finish_out) wait_fin(0, "store");
    end else begin
      wait_fin(0, "store");
    end
    bus.rob_en_in = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [3:0] t);
    bus.lb_en_in = 1'b1;
    bus.lb_addr_in = addr;
    bus.lb_inst_type_in = t;
    push_load(addr, t, cyc);
    wait_fin(1, "load");
    bus.lb_en_in = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] pc);
    bus.if_en_in = 1'b1;
    bus.if_pc_in = pc;
    push_fetch(pc, cyc);
    wait_fin(2, "fetch");
    bus.if_en_in = 1'b0;
  endtask

  // All three owners request at once; each drops its request on its own pulse.
  task automatic do_triple(input logic [31:0] sa, input logic [31:0] sd, input logic [3:0] st,
                           input logic [31:0] la, input logic [3:0] lt, input logic [31:0] pc);
    int c0 = cyc;
    int fs, fl;
    bus.rob_en_in = 1'b1; bus.rob_addr_in = sa; bus.rob_wdata_in = sd; bus.rob_inst_type_in = st;
    bus.lb_en_in = 1'b1;  bus.lb_addr_in = la;  bus.lb_inst_type_in = lt;
    bus.if_en_in = 1'b1;  bus.if_pc_in = pc;
    push_store(sa, sd, st, 0, c0);
    fs = c0 + tsize(st) + 2;
    push_load(la, lt, fs);
    fl = fs + tsize(lt) + 2;
    push_fetch(pc, fl);
    fork
      begin wait_fin(0, "tri_store"); bus.rob_en_in = 1'b0; end
      begin wait_fin(1, "tri_load");  bus.lb_en_in = 1'b0;  end
      begin wait_fin(2, "tri_fetch"); bus.if_en_in = 1'b0;  end
    join
  endtask

  task automatic rand_type_store(output logic [3:0] t);
    case ($urandom_range(0, 2))
      0:       t = SB;
      1:       t = SH;
      default: t = SW;
    endcase
  endtask

  task automatic rand_type_load(output logic [3:0] t);
    case ($urandom_range(0, 4))
      0:       t = LB;
      1:       t = LH;
      2:       t = LW;
      3:       t = LBU;
      default: t = LHU;
    endcase
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int c0;
    logic [7:0] v;
    logic [3:0] ts, tl;
    bus.rdy_in = 1'b1;
    bus.flush_in = 1'b0;
    bus.io_buffer_full = 1'b0;
    bus.rob_en_in = 1'b0; bus.rob_addr_in = '0; bus.rob_wdata_in = '0; bus.rob_inst_type_in = '0;
    bus.lb_en_in = 1'b0;  bus.lb_addr_in = '0;  bus.lb_inst_type_in = '0;
    bus.if_en_in = 1'b0;  bus.if_pc_in = '0;
    for (int i = 0; i < 1024; i++) begin
      v = 8'($urandom);
      if (i == 32'h20) v = 8'h80;
      ram[i] <= v;
      ref_mem[i] = v;
    end

    #2 rst = 1'b1;
    #1;
    check("rst_rob_rdy", {31'd0, bus.rob_rdy_out}, 32'd0);
    check("rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    check("rst_mem_a", bus.mem_a, 32'd0);
    check("rst_finishes", {29'd0, bus.rob_finish_out, bus.lb_finish_out, bus.if_finish_out}, 32'd0);
    check("rst_lb_data", bus.lb_data_out, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_rob_rdy_low", {31'd0, bus.rob_rdy_out}, 32'd0);
    wait_cycle();
    check("rel_rob_rdy_high", {31'd0, bus.rob_rdy_out}, 32'd1);

    do_store(32'h100, 32'h11223344, SW, 0);
    do_load(32'h20, LB);
    check("lb_sign_80", bus.lb_data_out, 32'hFFFFFF80);
    do_load(32'h20, LBU);
    check("lbu_zero_80", bus.lb_data_out, 32'h00000080);
    do_load(32'h100, LW);

    do_triple(32'h104, 32'hCAFEF00D, SW, 32'h104, LW, 32'h100);

    // Flush during cycle 3 of a fetch: abandoned, no pulse, instruction held.
    wait_cycle();
    c0 = cyc;
    bus.if_en_in = 1'b1;
    bus.if_pc_in = 32'h180;
    while (cyc < c0 + 3) wait_cycle();
    bus.flush_in = 1'b1;
    bus.if_en_in = 1'b0;
    wait_cycle();
    bus.flush_in = 1'b0;
    check("flush_fetch_idle", {31'd0, bus.rob_rdy_out}, 32'd1);
    check("flush_if_hold", bus.if_inst_out, last_if);
    repeat (8) wait_cycle();

    do_store(32'h140, 32'h0000BEEF, SH, 3);
    do_load(32'h140, LHU);

    // IO store held off by a full buffer for three cycles.
    c0 = cyc;
    bus.rob_en_in = 1'b1;
    bus.rob_addr_in = IO_ADDR_0;
    bus.rob_wdata_in = 32'h41;
    bus.rob_inst_type_in = SB;
    push_store(IO_ADDR_0, 32'h41, SB, 3, c0);
    wait_cycle();
    wait_cycle();
    bus.io_buffer_full = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("io_stall_wr", {31'd0, bus.mem_wr}, 32'd0);
      wait_cycle();
    end
    bus.io_buffer_full = 1'b0;
    wait_fin(0, "io_store");
    bus.rob_en_in = 1'b0;

    // Reset while the third byte of a word store is on the bus.
    c0 = cyc;
    bus.rob_en_in = 1'b1;
    bus.rob_addr_in = 32'h200;
    bus.rob_wdata_in = 32'hA1B2C3D4;
    bus.rob_inst_type_in = SW;
    wr_q.push_back('{32'h200, 8'hD4});
    wr_q.push_back('{32'h201, 8'hC3});
    ref_mem[32'h200] = 8'hD4;
    ref_mem[32'h201] = 8'hC3;
    while (cyc < c0 + 4) wait_cycle();
    rst = 1'b1;
    bus.rob_en_in = 1'b0;
    #1;
    check("midrst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    check("midrst_rob_rdy", {31'd0, bus.rob_rdy_out}, 32'd0);
    check("midrst_mem_a", bus.mem_a, 32'd0);
    check("midrst_if_inst", bus.if_inst_out, 32'd0);
    check("midrst_lb_data", bus.lb_data_out, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_if = 32'd0;
    wait_cycle();
    check("midrst_rdy_after", {31'd0, bus.rob_rdy_out}, 32'd1);
    do_load(32'h200, LW);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a, d, a2, pc;
      a  = $urandom_range(0, 1020);
      a2 = $urandom_range(0, 1020);
      pc = $urandom_range(0, 1020);
      d  = $urandom;
      rand_type_store(ts);
      rand_type_load(tl);
      case ($urandom_range(0, 9))
        0, 1, 2, 3: do_store(a, d, ts, 0);
        4, 5, 6:    do_load(a, tl);
        7, 8:       do_fetch(pc);
        default:    do_triple(a, d, ts, a2, tl, pc);
      endcase
      repeat ($urandom_range(0, 2)) wait_cycle();
    end

    repeat (5) wait_cycle();
    check("queues_empty", 32'(wr_q.size() + st_q.size() + lb_q.size() + if_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
